// File: rtl/lsu_wait_state.sv
// lsu_wait_state: clocked load/store unit issuing one memory request per instruction, with wait states and a watchdog.
// Ports: clk/rst_n (async active-low); start + instruction begin an op; busy/done/err report progress;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready form the memory port;
//        regs_output reads the register file, regs_input/regs_write_en write it back on loads.
module lsu_wait_state #(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_W     = 11,
    parameter int MEM_ADDR_W = 16,
    parameter int TIMEOUT    = 15,
    parameter int INSTR_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [INSTR_W-1:0]           instruction,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [MEM_ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ready,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_output,
    output logic [DATA_W-1:0]            regs_input,
    output logic [NUM_REGS-1:0]          regs_write_en
);
    localparam int REG_SEL_W = $clog2(NUM_REGS);
    localparam int CNT_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WB, DONE, ERR} state_t;

    state_t                r_state, w_next;
    logic [REG_SEL_W-1:0]  r_sel;
    logic                  r_store;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata, r_rdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_accept, w_store, w_timeout;
    logic [REG_SEL_W-1:0]  w_sel;

    assign w_accept  = start && instruction[INSTR_W-1 -: 2] == 2'b01;
    assign w_store   = instruction[INSTR_W-3];
    assign w_sel     = instruction[INSTR_W-4 -: REG_SEL_W];
    // Last permitted wait cycle: a ready here still wins over the abort.
    assign w_timeout = r_cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        w_next        = r_state;
        busy          = r_state != IDLE;
        done          = r_state == DONE;
        err           = r_state == ERR;
        mem_req       = r_state == REQ;
        mem_we        = r_state == REQ && r_store;
        mem_addr      = r_addr;
        mem_wdata     = r_wdata;
        regs_input    = r_rdata;
        regs_write_en = r_state == WB ? NUM_REGS'(1) << r_sel : '0;
        case (r_state)
            IDLE:    w_next = w_accept ? REQ : IDLE;
            REQ:     w_next = mem_ready ? (r_store ? DONE : WB) : (w_timeout ? ERR : REQ);
            WB:      w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_store <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_accept) begin
                r_sel   <= w_sel;
                r_store <= w_store;
                r_addr  <= MEM_ADDR_W'(instruction[ADDR_W-1:0]);
                // Store data is snapshotted so register updates during the request cannot disturb it.
                if (w_store)
                    r_wdata <= regs_output[w_sel*DATA_W +: DATA_W];
            end
            if (r_state == REQ && mem_ready && !r_store)
                r_rdata <= mem_rdata;
            if (r_state == REQ && !mem_ready)
                r_cnt <= r_cnt + 1'b1;
            else if (r_state == DONE || r_state == ERR)
                r_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_lsu_wait_state.sv
// tb_lsu_wait_state: directed scoreboard bench for lsu_wait_state (default and widened parameter sets).
module tb_lsu_wait_state;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instruction = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, regs_input;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] regs_output = 32'h5C33_2211;
    logic [3:0]  regs_write_en;

    logic        p_start = 1'b0;
    logic [17:0] p_instruction = '0;
    logic        p_busy, p_done, p_err, p_mem_req, p_mem_we;
    logic [15:0] p_mem_addr, p_mem_wdata, p_regs_input;
    logic [15:0] p_mem_rdata = '0;
    logic        p_mem_ready = 1'b0;
    logic [127:0] p_regs_output = '0;
    logic [7:0]  p_regs_write_en;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {logic [3:0] en; logic [7:0] d;} wr_t;
    wr_t  wq[$];
    logic eq[$];

    always #5 clk = ~clk;

    lsu_wait_state dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
        .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .regs_output(regs_output), .regs_input(regs_input), .regs_write_en(regs_write_en)
    );

    lsu_wait_state #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(12), .INSTR_W(18)) dut_p (
        .clk(clk), .rst_n(rst_n), .start(p_start), .instruction(p_instruction),
        .busy(p_busy), .done(p_done), .err(p_err), .mem_req(p_mem_req), .mem_we(p_mem_we),
        .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
        .regs_output(p_regs_output), .regs_input(p_regs_input), .regs_write_en(p_regs_write_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and retire any write or completion against the scoreboard.
    task automatic cyc();
        wr_t w;
        logic e;
        @(negedge clk);
        if (regs_write_en !== 4'b0) begin
            if (wq.size() == 0) chk("sb_unexpected_write", 32'(regs_write_en), 32'h0);
            else begin
                w = wq.pop_front();
                chk("sb_wr_en", 32'(regs_write_en), 32'(w.en));
                chk("sb_wr_data", 32'(regs_input), 32'(w.d));
            end
        end
        if (done || err) begin
            if (eq.size() == 0) chk("sb_unexpected_end", 32'({done, err}), 32'h0);
            else begin
                e = eq.pop_front();
                chk("sb_end", 32'({done, err}), e ? 32'h1 : 32'h2);
            end
        end
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_rin", 32'(regs_input), 0);
        chk("rst_wen", 32'(regs_write_en), 0);
        rst_n = 1'b1;
        cyc();

        // zero-wait load r1 <- [0x025]
        start = 1; instruction = 16'h4825; mem_ready = 1; mem_rdata = 8'hA5;
        wq.push_back('{4'b0010, 8'hA5}); eq.push_back(1'b0);
        cyc(); start = 0;
        chk("zl_req", 32'(mem_req), 1);
        chk("zl_addr", 32'(mem_addr), 32'h25);
        chk("zl_we", 32'(mem_we), 0);
        chk("zl_busy", 32'(busy), 1);
        cyc();
        chk("zl_wen", 32'(regs_write_en), 32'b0010);
        chk("zl_rin", 32'(regs_input), 32'hA5);
        chk("zl_req_off", 32'(mem_req), 0);
        cyc();
        chk("zl_done", 32'(done), 1);
        cyc();
        chk("zl_idle_busy", 32'(busy), 0);
        chk("zl_idle_done", 32'(done), 0);

        // store r3 (0x5C) -> [0x7FF] with three wait states, plus an ignored start mid-request
        start = 1; instruction = 16'h7FFF; mem_ready = 0;
        eq.push_back(1'b0);
        cyc(); start = 0;
        regs_output[31:24] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk("st_req", 32'(mem_req), 1);
            chk("st_we", 32'(mem_we), 1);
            chk("st_wdata", 32'(mem_wdata), 32'h5C);
            chk("st_addr", 32'(mem_addr), 32'h07FF);
            chk("st_wen", 32'(regs_write_en), 0);
            start = (i == 1); instruction = 16'h4123;
            mem_ready = (i == 3);
            cyc();
        end
        start = 0; mem_ready = 0;
        chk("st_done", 32'(done), 1);
        chk("st_req_off", 32'(mem_req), 0);
        cyc();
        chk("st_idle", 32'(busy), 0);
        chk("st_addr_hold", 32'(mem_addr), 32'h07FF);

        // timeout on load r0
        start = 1; instruction = 16'h4001;
        eq.push_back(1'b1);
        cyc(); start = 0;
        for (int i = 0; i < 15; i++) begin
            chk("to_req", 32'(mem_req), 1);
            cyc();
        end
        chk("to_err", 32'(err), 1);
        chk("to_done", 32'(done), 0);
        chk("to_req_off", 32'(mem_req), 0);
        chk("to_wen", 32'(regs_write_en), 0);
        cyc();
        chk("to_busy_off", 32'(busy), 0);

        // ready on the last permitted wait cycle is a success: load r2 <- [0x3AB]
        start = 1; instruction = 16'h53AB; mem_rdata = 8'h3C;
        wq.push_back('{4'b0100, 8'h3C}); eq.push_back(1'b0);
        cyc(); start = 0;
        for (int i = 0; i < 15; i++) begin
            chk("edge_req", 32'(mem_req), 1);
            mem_ready = (i == 14);
            cyc();
        end
        mem_ready = 0;
        chk("edge_wen", 32'(regs_write_en), 32'b0100);
        chk("edge_err", 32'(err), 0);
        cyc(); cyc();

        // start with opcode 00 is ignored
        start = 1; instruction = 16'h0825;
        cyc(); start = 0;
        chk("ign_busy", 32'(busy), 0);
        chk("ign_req", 32'(mem_req), 0);
        cyc();
        chk("ign_busy2", 32'(busy), 0);

        // asynchronous reset in the middle of a request
        start = 1; instruction = 16'h4825;
        cyc(); start = 0;
        cyc();
        chk("ar_pre_req", 32'(mem_req), 1);
        #2 rst_n = 0;
        #1;
        chk("ar_req", 32'(mem_req), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_wen", 32'(regs_write_en), 0);
        cyc();
        rst_n = 1;
        cyc();
        start = 1; instruction = 16'h5010; mem_ready = 1; mem_rdata = 8'h77;
        wq.push_back('{4'b0100, 8'h77}); eq.push_back(1'b0);
        cyc(); start = 0;
        chk("ar_new_addr", 32'(mem_addr), 32'h0010);
        cyc();
        chk("ar_new_wen", 32'(regs_write_en), 32'b0100);
        cyc();
        chk("ar_new_done", 32'(done), 1);
        mem_ready = 0;
        cyc();

        // widened instance: load r6 <- [0xABC]
        p_start = 1; p_instruction = 18'h16ABC; p_mem_ready = 1; p_mem_rdata = 16'hBEEF;
        cyc(); p_start = 0;
        chk("p_req", 32'(p_mem_req), 1);
        chk("p_addr", 32'(p_mem_addr), 32'h0ABC);
        cyc();
        chk("p_wen", 32'(p_regs_write_en), 32'h40);
        chk("p_rin", 32'(p_regs_input), 32'hBEEF);
        cyc();
        chk("p_done", 32'(p_done), 1);
        cyc();
        chk("p_idle", 32'(p_busy), 0);

        chk("sb_wq_empty", 32'(wq.size()), 0);
        chk("sb_eq_empty", 32'(eq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
